// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped 2-bit direction predictor with target buffer and ID-stage mispredict/redirect.
// Defining BP_STATS_EN adds stat_branches/stat_mispred counters.
module branch_predictor #(
    parameter int IDX_W = 4,
    localparam int TAG_W = 30 - IDX_W
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
`endif
);
    localparam int N = 2 ** IDX_W;

    logic             valid  [N];
    logic [TAG_W-1:0] tag    [N];
    logic [31:0]      target [N];
    logic [1:0]       ctr    [N];

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             l_hit, u_hit;
    logic             unused_ok;

    assign l_idx     = if_pc[IDX_W+1:2];
    assign l_tag     = if_pc[31:IDX_W+2];
    assign u_idx     = upd_pc[IDX_W+1:2];
    assign u_tag     = upd_pc[31:IDX_W+2];
    assign unused_ok = ^if_pc[1:0];

    assign l_hit       = valid[l_idx] && tag[l_idx] == l_tag;
    assign u_hit       = valid[u_idx] && tag[u_idx] == u_tag;
    assign pred_taken  = l_hit && ctr[l_idx][1];
    assign pred_target = l_hit ? target[l_idx] : 32'd0;

    assign mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                         (upd_taken && upd_pred_taken && upd_target != upd_pred_target));
    assign redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;

    // A taken miss evicts whatever occupies the slot; not-taken misses never allocate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                valid[i]  <= 1'b0;
                tag[i]    <= '0;
                target[i] <= 32'd0;
                ctr[i]    <= 2'b01;
            end
        end else if (upd_valid) begin
            if (u_hit && upd_taken) begin
                ctr[u_idx]    <= ctr[u_idx] == 2'b11 ? 2'b11 : ctr[u_idx] + 2'd1;
                target[u_idx] <= upd_target;
            end else if (u_hit) begin
                ctr[u_idx] <= ctr[u_idx] == 2'b00 ? 2'b00 : ctr[u_idx] - 2'd1;
            end else if (upd_taken) begin
                valid[u_idx]  <= 1'b1;
                tag[u_idx]    <= u_tag;
                target[u_idx] <= upd_target;
                ctr[u_idx]    <= 2'b10;
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_branches <= 32'd0;
            stat_mispred  <= 32'd0;
        end else begin
            if (upd_valid) stat_branches <= stat_branches + 32'd1;
            if (mispredict) stat_mispred <= stat_mispred + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vectors with hand-computed expectations for branch_predictor.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] if_pc = 32'd0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'd0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = 32'd0;
    logic        upd_pred_taken = 1'b0;
    logic [31:0] upd_pred_target = 32'd0;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches, stat_mispred;
`endif
    int n_vec = 0;
    int n_err = 0;

    branch_predictor dut (
        .clk(clk), .reset_n(reset_n), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BP_STATS_EN
        , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic t, input logic [31:0] tg);
        if_pc = pc;
        #1;
        chk({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, t});
        chk({tag, ".target"}, pred_target, tg);
    endtask

    task automatic drive(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                         input logic pt, input logic [31:0] ptg);
        upd_valid = 1'b1;
        upd_pc = pc;
        upd_taken = tk;
        upd_target = tg;
        upd_pred_taken = pt;
        upd_pred_target = ptg;
        #1;
    endtask

    task automatic res(input string tag, input logic m, input logic [31:0] rpc);
        chk({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, m});
        if (m) chk({tag, ".redirect"}, redirect_pc, rpc);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    initial begin
        // Reset state; mispredict stays combinational during reset
        if_pc = 32'h0040_0010;
        #12;
        look("rst", 32'h0040_0010, 1'b0, 32'd0);
        chk("rst.mp_idle", {31'd0, mispredict}, 32'd0);
        drive(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'd0);
        res("rst.mp_comb", 1'b1, 32'h0040_0040);
        upd_valid = 1'b0;
`ifdef BP_STATS_EN
        chk("rst.stat_br", stat_branches, 32'd0);
        chk("rst.stat_mp", stat_mispred, 32'd0);
`endif
        reset_n = 1'b1;
        tick;

        // First encounter of a taken branch; lookup in same cycle sees old (empty) entry
        drive(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'd0);
        res("first", 1'b1, 32'h0040_0040);
        look("first.rbw", 32'h0040_0010, 1'b0, 32'd0);
        tick;
        look("first.after", 32'h0040_0010, 1'b1, 32'h0040_0040);

        // Saturate to 3, then two not-takens for hysteresis
        for (int i = 0; i < 3; i++) begin
            drive(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b1, 32'h0040_0040);
            res("sat", 1'b0, 32'd0);
            tick;
        end
        drive(32'h0040_0010, 1'b0, 32'h0040_0040, 1'b1, 32'h0040_0040);
        res("nt1", 1'b1, 32'h0040_0014);
        tick;
        look("nt1.after", 32'h0040_0010, 1'b1, 32'h0040_0040);
        drive(32'h0040_0010, 1'b0, 32'h0040_0040, 1'b1, 32'h0040_0040);
        look("nt2.rbw", 32'h0040_0010, 1'b1, 32'h0040_0040);
        tick;
        look("nt2.after", 32'h0040_0010, 1'b0, 32'h0040_0040);

        // Floor at 0: three more not-takens then one taken leaves ctr=1
        for (int i = 0; i < 3; i++) begin
            drive(32'h0040_0010, 1'b0, 32'h0040_0040, 1'b0, 32'd0);
            res("floor", 1'b0, 32'd0);
            tick;
        end
        drive(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'd0);
        tick;
        look("floor.after", 32'h0040_0010, 1'b0, 32'h0040_0040);

        // Both taken, wrong target -> redirect; target is retrained
        drive(32'h0040_0010, 1'b1, 32'h0040_0080, 1'b1, 32'h0040_0040);
        res("tgt", 1'b1, 32'h0040_0080);
        tick;
        look("tgt.after", 32'h0040_0010, 1'b1, 32'h0040_0080);

        // Aliasing at index 4 evicts the 0x00400010 entry
        drive(32'h0040_0050, 1'b1, 32'h0040_0100, 1'b0, 32'd0);
        tick;
        look("alias.old", 32'h0040_0010, 1'b0, 32'd0);
        look("alias.new", 32'h0040_0050, 1'b1, 32'h0040_0100);

        // Not-taken miss does not allocate
        drive(32'h0040_0020, 1'b0, 32'h0040_0200, 1'b0, 32'd0);
        res("ntmiss", 1'b0, 32'd0);
        chk("ntmiss.redirect", redirect_pc, 32'h0040_0024);
        tick;
        drive(32'h0040_0020, 1'b1, 32'h0040_0200, 1'b0, 32'd0);
        upd_valid = 1'b0;
        look("ntmiss.after", 32'h0040_0020, 1'b0, 32'd0);

        // PC+4 wraps at the top of the address space
        drive(32'hFFFF_FFFC, 1'b0, 32'd0, 1'b1, 32'h0000_1000);
        res("wrap", 1'b1, 32'h0000_0000);
        tick;

        // upd_valid=0: no mispredict, no training
        drive(32'h0040_0050, 1'b0, 32'd0, 1'b1, 32'h0040_0100);
        upd_valid = 1'b0;
        #1;
        res("idle", 1'b0, 32'd0);
        tick;
        tick;
        look("idle.after", 32'h0040_0050, 1'b1, 32'h0040_0100);

        // Reset asserted with an update pending: update lost, table cleared
        drive(32'h0040_0060, 1'b1, 32'h0040_0300, 1'b0, 32'd0);
        #2;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        upd_valid = 1'b0;
        look("midrst.new", 32'h0040_0060, 1'b0, 32'd0);
        look("midrst.old", 32'h0040_0050, 1'b0, 32'd0);

        // Five updates, two mispredicts
        drive(32'h0040_0070, 1'b1, 32'h0040_0400, 1'b0, 32'd0);
        res("st1", 1'b1, 32'h0040_0400);
        tick;
        drive(32'h0040_0070, 1'b1, 32'h0040_0400, 1'b1, 32'h0040_0400);
        res("st2", 1'b0, 32'd0);
        tick;
        drive(32'h0040_0070, 1'b1, 32'h0040_0400, 1'b1, 32'h0040_0400);
        res("st3", 1'b0, 32'd0);
        tick;
        drive(32'h0040_0070, 1'b0, 32'h0040_0400, 1'b1, 32'h0040_0400);
        res("st4", 1'b1, 32'h0040_0074);
        tick;
        drive(32'h0040_0070, 1'b0, 32'h0040_0400, 1'b0, 32'd0);
        res("st5", 1'b0, 32'd0);
        tick;
        look("st.after", 32'h0040_0070, 1'b0, 32'h0040_0400);
`ifdef BP_STATS_EN
        chk("stat_br", stat_branches, 32'd5);
        chk("stat_mp", stat_mispred, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
